rst_sequencer: RTL and testbench



---
 rtl/rst_seq_pkg.sv | 22 ++
 rtl/sync_bit.sv | 24 ++
 rtl/rst_sequencer.sv | 133 +++++++++++++
 tb/tb_rst_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encodings and a
// constant-function helper for sizing the release index.
package rst_seq_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] HOLD      = 3'd0;
    localparam logic [STATE_W-1:0] WAIT_LOCK = 3'd1;
    localparam logic [STATE_W-1:0] RELEASE   = 3'd2;
    localparam logic [STATE_W-1:0] RUN       = 3'd3;
    localparam logic [STATE_W-1:0] SOFT      = 3'd4;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop single-bit synchroniser with an asynchronous active-low clear.
// With d tied high it acts as a reset-deassertion synchroniser.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset sequencer: waits for a synchronised reset release and a stable
// PLL lock, then releases NUM_OUT active-low resets one at a time.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_OUT     = 3,
    parameter int STAGE_DELAY = 16,
    parameter int SOFT_HOLD   = 8,
    parameter int CNT_W       = 8
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic               pll_locked,
    input  logic               soft_rst_req,
    output logic [NUM_OUT-1:0] rst_out_n,
    output logic               seq_done,
    output logic               soft_rst_ack,
    output logic [STATE_W-1:0] seq_state
);

    localparam int KW = (clog2(NUM_OUT) > 0) ? clog2(NUM_OUT) : 1;

    localparam logic [CNT_W-1:0]   STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0]   SOFT_LAST  = CNT_W'(SOFT_HOLD - 1);
    localparam logic [KW-1:0]      LAST_K     = KW'(NUM_OUT - 1);
    localparam logic [NUM_OUT-1:0] FIRST_BIT  = NUM_OUT'(1);

    typedef enum logic [STATE_W-1:0] {
        S_HOLD      = HOLD,
        S_WAIT_LOCK = WAIT_LOCK,
        S_RELEASE   = RELEASE,
        S_RUN       = RUN,
        S_SOFT      = SOFT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [KW-1:0]    k;
    logic             rst_sync;
    logic             lock_s;
    logic             lock_lost;

    sync_bit #(.STAGES(SYNC_STAGES)) u_rst_sync (
        .sys_clk (sys_clk),
        .reset   (reset),
        .d       (1'b1),
        .q       (rst_sync)
    );

    sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .sys_clk (sys_clk),
        .reset   (reset),
        .d       (pll_locked),
        .q       (lock_s)
    );

    // Lock loss outranks a soft request and a soft-hold completion on the same edge.
    assign lock_lost = !lock_s &&
                       (state == S_RELEASE || state == S_RUN || state == S_SOFT);

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state        <= S_HOLD;
            cnt          <= '0;
            k            <= '0;
            rst_out_n    <= '0;
            seq_done     <= 1'b0;
            soft_rst_ack <= 1'b0;
        end else begin
            soft_rst_ack <= 1'b0;
            if (lock_lost) begin
                state     <= S_WAIT_LOCK;
                cnt       <= '0;
                k         <= '0;
                rst_out_n <= '0;
                seq_done  <= 1'b0;
            end else begin
                case (state)
                    S_HOLD: begin
                        if (rst_sync) begin
                            state <= S_WAIT_LOCK;
                        end
                    end
                    S_WAIT_LOCK: begin
                        if (lock_s) begin
                            state <= S_RELEASE;
                            cnt   <= '0;
                            k     <= '0;
                        end
                    end
                    S_RELEASE: begin
                        if (cnt == STAGE_LAST) begin
                            rst_out_n <= rst_out_n | (FIRST_BIT << k);
                            cnt       <= '0;
                            k         <= k + 1'b1;
                            if (k == LAST_K) begin
                                state    <= S_RUN;
                                seq_done <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (soft_rst_req) begin
                            state     <= S_SOFT;
                            rst_out_n <= '0;
                            seq_done  <= 1'b0;
                            cnt       <= '0;
                        end
                    end
                    S_SOFT: begin
                        if (cnt == SOFT_LAST) begin
                            soft_rst_ack <= 1'b1;
                            state        <= S_RELEASE;
                            cnt          <= '0;
                            k            <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= S_HOLD;
                    end
                endcase
            end
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: a segment table drives the main sequences,
// hand-written sequences cover late lock and asynchronous resets.
module tb_rst_sequencer;
    import rst_seq_pkg::*;

    logic       sys_clk;
    logic       reset;
    logic       pll_locked;
    logic       soft_rst_req;
    logic [2:0] rst_out_n;
    logic       seq_done;
    logic       soft_rst_ack;
    logic [2:0] seq_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       pll;
        logic       req;
        int         cycles;
        logic [2:0] out;
        logic       done;
        logic       ack;
        logic [2:0] st;
    } vec_t;

    vec_t vecs[$];

    rst_sequencer #(
        .SYNC_STAGES (2),
        .NUM_OUT     (3),
        .STAGE_DELAY (4),
        .SOFT_HOLD   (3),
        .CNT_W       (8)
    ) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .rst_out_n    (rst_out_n),
        .seq_done     (seq_done),
        .soft_rst_ack (soft_rst_ack),
        .seq_state    (seq_state)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic add(input logic r, input logic p, input logic q, input int c,
                       input logic [2:0] o, input logic d, input logic a,
                       input logic [2:0] s);
        vec_t v;
        v.rst = r; v.pll = p; v.req = q; v.cycles = c;
        v.out = o; v.done = d; v.ack = a; v.st = s;
        vecs.push_back(v);
    endtask

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] o, input logic d,
                             input logic a, input logic [2:0] s);
        check_output({tag, ".rst_out_n"}, int'(rst_out_n), int'(o));
        check_output({tag, ".seq_done"}, int'(seq_done), int'(d));
        check_output({tag, ".soft_rst_ack"}, int'(soft_rst_ack), int'(a));
        check_output({tag, ".seq_state"}, int'(seq_state), int'(s));
    endtask

    // Drives one table segment and checks the held expectation after every edge.
    task automatic apply_stimulus(input int idx);
        vec_t v;
        v = vecs[idx];
        reset        = v.rst;
        pll_locked   = v.pll;
        soft_rst_req = v.req;
        for (int c = 0; c < v.cycles; c++) begin
            @(negedge sys_clk);
            check_all($sformatf("row%0d/c%0d", idx, c), v.out, v.done, v.ack, v.st);
        end
    endtask

    initial begin
        logic [2:0] exp_out;
        logic [2:0] exp_st;

        // Power-up and first release (edges counted from reset release).
        add(0, 1, 0, 3, 3'b000, 0, 0, HOLD);
        add(1, 1, 0, 2, 3'b000, 0, 0, HOLD);
        add(1, 1, 0, 1, 3'b000, 0, 0, WAIT_LOCK);
        add(1, 1, 0, 4, 3'b000, 0, 0, RELEASE);
        add(1, 1, 0, 4, 3'b001, 0, 0, RELEASE);
        add(1, 1, 0, 4, 3'b011, 0, 0, RELEASE);
        add(1, 1, 0, 2, 3'b111, 1, 0, RUN);
        // One-cycle soft reset request.
        add(1, 1, 1, 1, 3'b000, 0, 0, SOFT);
        add(1, 1, 0, 2, 3'b000, 0, 0, SOFT);
        add(1, 1, 0, 1, 3'b000, 0, 1, RELEASE);
        add(1, 1, 0, 3, 3'b000, 0, 0, RELEASE);
        add(1, 1, 0, 4, 3'b001, 0, 0, RELEASE);
        add(1, 1, 0, 4, 3'b011, 0, 0, RELEASE);
        add(1, 1, 0, 2, 3'b111, 1, 0, RUN);
        // Second soft reset, then lock drop while two bits are released.
        add(1, 1, 1, 1, 3'b000, 0, 0, SOFT);
        add(1, 1, 0, 2, 3'b000, 0, 0, SOFT);
        add(1, 1, 0, 1, 3'b000, 0, 1, RELEASE);
        add(1, 1, 0, 3, 3'b000, 0, 0, RELEASE);
        add(1, 1, 0, 4, 3'b001, 0, 0, RELEASE);
        add(1, 1, 0, 1, 3'b011, 0, 0, RELEASE);
        add(1, 0, 0, 2, 3'b011, 0, 0, RELEASE);
        add(1, 0, 0, 3, 3'b000, 0, 0, WAIT_LOCK);
        add(1, 1, 0, 2, 3'b000, 0, 0, WAIT_LOCK);
        add(1, 1, 0, 4, 3'b000, 0, 0, RELEASE);
        add(1, 1, 0, 4, 3'b001, 0, 0, RELEASE);
        add(1, 1, 0, 4, 3'b011, 0, 0, RELEASE);
        add(1, 1, 0, 1, 3'b111, 1, 0, RUN);
        // Lock loss meets a soft request on the same edge: lock loss wins.
        add(1, 0, 0, 2, 3'b111, 1, 0, RUN);
        add(1, 0, 1, 1, 3'b000, 0, 0, WAIT_LOCK);
        // Request held through WAIT_LOCK/RELEASE and dropped before RUN is ignored.
        add(1, 1, 1, 2, 3'b000, 0, 0, WAIT_LOCK);
        add(1, 1, 1, 4, 3'b000, 0, 0, RELEASE);
        add(1, 1, 1, 4, 3'b001, 0, 0, RELEASE);
        add(1, 1, 0, 4, 3'b011, 0, 0, RELEASE);
        add(1, 1, 0, 2, 3'b111, 1, 0, RUN);
        // Request held across the whole soft cycle re-triggers on RUN entry.
        add(1, 1, 1, 1, 3'b000, 0, 0, SOFT);
        add(1, 1, 1, 2, 3'b000, 0, 0, SOFT);
        add(1, 1, 1, 1, 3'b000, 0, 1, RELEASE);
        add(1, 1, 1, 3, 3'b000, 0, 0, RELEASE);
        add(1, 1, 1, 4, 3'b001, 0, 0, RELEASE);
        add(1, 1, 1, 4, 3'b011, 0, 0, RELEASE);
        add(1, 1, 1, 1, 3'b111, 1, 0, RUN);
        add(1, 1, 1, 1, 3'b000, 0, 0, SOFT);
        add(1, 1, 0, 2, 3'b000, 0, 0, SOFT);
        add(1, 1, 0, 1, 3'b000, 0, 1, RELEASE);

        reset        = 1'b0;
        pll_locked   = 1'b1;
        soft_rst_req = 1'b0;
        #1;
        check_all("reset_state", 3'b000, 0, 0, HOLD);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(i);
        end

        // Asynchronous reset mid-RELEASE, then a late PLL lock.
        repeat (2) @(negedge sys_clk);
        #2 reset = 1'b0;
        #1 check_all("async_rst_release", 3'b000, 0, 0, HOLD);
        pll_locked = 1'b0;
        @(negedge sys_clk);
        reset = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            @(negedge sys_clk);
            exp_st  = (e < 3) ? HOLD : (e < 13) ? WAIT_LOCK : (e < 25) ? RELEASE : RUN;
            exp_out = (e >= 25) ? 3'b111 : (e >= 21) ? 3'b011 : (e >= 17) ? 3'b001 : 3'b000;
            check_all($sformatf("late_lock/e%0d", e), exp_out, (e >= 25), 0, exp_st);
            if (e == 10) pll_locked = 1'b1;
        end

        // Asynchronous reset mid-SOFT, then the power-up timing again.
        soft_rst_req = 1'b1;
        @(negedge sys_clk);
        soft_rst_req = 1'b0;
        check_all("soft_entry", 3'b000, 0, 0, SOFT);
        @(negedge sys_clk);
        #3 reset = 1'b0;
        #1 check_all("async_rst_soft", 3'b000, 0, 0, HOLD);
        @(negedge sys_clk);
        for (int i = 1; i <= 6; i++) begin
            apply_stimulus(i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
